ahb_lite_mem_responder: RTL and testbench
=========================================

Name: ahb_lite_mem_responder

Overview:
- AHB-Lite slave (responder) with an internal word-addressed memory, for simulation and bring-up.
- It answers the transfers issued by the AHB-Lite master BFM and its AHB-to-APB bridge path, as the other end of the same bus.
- It supports programmable wait states, byte/halfword/word writes, and a two-cycle ERROR response for a programmable address window and for illegal accesses.

Parameters:
- AWIDTH, 10, word-address bits. Memory is 2^AWIDTH 32-bit words, indexed by HADDR[AWIDTH+1:2]. Upper HADDR bits are ignored apart from the error-window check.
- WAIT_STATES, 0, number of HREADYOUT-low cycles inserted per OKAY transfer. Range 0..15.
- ERR_MASK, 32'h0000_0000, error-window mask. 0 disables the window.
- ERR_MATCH, 32'h0000_0000, an address is in the error window when (HADDR & ERR_MASK) == ERR_MATCH and ERR_MASK != 0.

Ports:
- HCLK  in  1  bus clock; all logic is on its rising edge.
- HRESET  in  1  reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address.
- HWRITE  in  1  1 = write.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HSIZE  in  3  000 byte, 001 halfword, 010 word; others illegal.
- HBURST  in  3  ignored; every beat is handled independently.
- HWDATA  in  32  write data, sampled in the data phase.
- HREADYIN  in  1  bus-wide HREADY.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Clock and reset: one clock, HCLK. Reset HRESET is synchronous and active-high.
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0. Memory contents are not cleared.
- Reset mid-transfer: the transfer is abandoned and no memory write occurs. Outputs take their reset values on the next edge.
- Address-phase accept: HSEL & HREADYIN & HTRANS[1] at a rising edge. On accept, latch HADDR, HWRITE and HSIZE.
- IDLE/BUSY with HSEL & HREADYIN: nothing is latched; zero-wait OKAY.
- Error condition, evaluated on the accept cycle, is any of:
  - HSIZE > 2;
  - HSIZE=1 with HADDR[0]=1;
  - HSIZE=2 with HADDR[1:0] != 0;
  - address inside the error window.
- State machine:
  - IDLE: HREADYOUT=1, HRESP=0.
    - On accept with error → ERR1.
    - On accept with WAIT_STATES>0 → WAIT, cnt=WAIT_STATES.
    - On accept with WAIT_STATES=0 → LAST.
  - WAIT: HREADYOUT=0, HRESP=0, cnt decrements each edge; cnt reaching 1 → LAST. This gives exactly WAIT_STATES low cycles.
  - LAST: HREADYOUT=1, HRESP=0.
    - Write: at the edge ending LAST, update memory byte lanes per latched HSIZE and HADDR[1:0], little-endian (byte n = HWDATA[8n+7:8n]); other lanes are unchanged.
    - Read: HRDATA = mem[latched word address] throughout LAST.
    - Next state is taken from a new accept in the same cycle (back-to-back pipelining), else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No memory write, HRDATA=0. Next state is taken from a new accept, else IDLE.
- HRDATA is 0 in every cycle other than LAST of a read.
- Read after write: a read accepted in the write's LAST cycle observes the newly written data, because the array updates at that edge and the read data phase follows it.
- HSEL=0 with a valid HTRANS while HREADYIN=1: no accept. A data phase already in progress continues unaffected.
- When HREADYIN=0 (another slave stalling), no accept occurs.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then back-to-back read of 0x10 → write LAST with HREADYOUT=1 and HRESP=0; read returns 0xDEADBEEF on the next cycle with no stall.
- Byte lanes: word write 0x11223344 to 0x20, byte write 0xAA at 0x21 (HWDATA=0x0000AA00), halfword write 0xBBCC at 0x22 (HWDATA=0xBBCC0000), read 0x20 → 0xBBCCAA44.
- WAIT_STATES=3: single read → exactly 3 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1 with valid data; 4-beat INCR4 burst → 16 total data-phase cycles.
- ERR_MASK=0xF000_0000, ERR_MATCH=0xF000_0000: write to 0xF000_0004 → HREADYOUT/HRESP = 0/1 then 1/1. A subsequent read of word index 1 shows the prior value unchanged.
- Illegal accesses: word write at 0x3 and HSIZE=3 read → each gives the two-cycle ERROR and no memory change.
- HRESET asserted during WAIT of a write (WAIT_STATES=5) → next cycle HREADYOUT=1, HRESP=0, HRDATA=0; a readback shows the target word not updated. IDLE/BUSY transfers with HSEL=1 → HREADYOUT stays 1, HRESP=0.

Source files
------------

// File: rtl/ahb_lite_mem_responder.sv
// AHB-Lite memory responder: word-addressed RAM answering bus transfers with
// programmable wait states, byte/halfword/word writes and a two-cycle ERROR.
module ahb_lite_mem_responder #(
  parameter int unsigned AWIDTH      = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ERR_MASK    = 32'h0000_0000,
  parameter logic [31:0] ERR_MATCH   = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned DEPTH    = 1 << AWIDTH;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AWIDTH+1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       mem [DEPTH];

  logic       accept, acc_err, in_window, data_open, mem_we;
  logic [3:0] lane_en;
  logic       unused_ok;

  // Burst type is irrelevant (each beat stands alone); upper address bits only feed the window.
  assign unused_ok = ^{HBURST, HTRANS[0], HADDR};

  assign accept    = HSEL & HREADYIN & HTRANS[1];
  assign in_window = (ERR_MASK != 32'h0) && ((HADDR & ERR_MASK) == ERR_MATCH);
  assign acc_err   = in_window
                   | (HSIZE > 3'd2)
                   | ((HSIZE == 3'd1) & HADDR[0])
                   | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

  // A new address phase can only be taken while this slave is driving HREADYOUT high.
  assign data_open = (state_q == ST_IDLE) || (state_q == ST_LAST) || (state_q == ST_ERR2);
  assign mem_we    = (state_q == ST_LAST) && write_q;

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;

    case (state_q)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_LAST;
      end
      ST_LAST: begin
        if (!write_q) HRDATA = mem[addr_q[AWIDTH+1:2]];
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ST_ERR2;
      end
      ST_ERR2: HRESP = 1'b1;
      ST_IDLE: ;
      default: state_d = ST_IDLE;
    endcase

    if (data_open) begin
      if (accept) begin
        addr_d  = HADDR[AWIDTH+1:0];
        write_d = HWRITE;
        size_d  = HSIZE[1:0];
        cnt_d   = WAIT_CNT;
        if (acc_err)               state_d = ST_ERR1;
        else if (WAIT_STATES > 0)  state_d = ST_WAIT;
        else                       state_d = ST_LAST;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Little-endian lane enables for the latched size/offset (only legal sizes reach LAST).
  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      2'd0:    lane_en[addr_q[1:0]] = 1'b1;
      2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // NOTE: the array has no reset; contents survive HRESET, and a reset abandons a pending write.
  always_ff @(posedge HCLK) begin
    if (!HRESET && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[addr_q[AWIDTH+1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_mem_responder.sv
// Randomised and directed bench for ahb_lite_mem_responder; three instances
// (0, 3 and 5 wait states) share one bus, one selected at a time.
module tb_ahb_lite_mem_responder;

  localparam logic [31:0] EWIN = 32'hF000_0000;

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
  } obs_t;

  typedef struct {
    bit          sel;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
    logic [2:0]  burst;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, hwrite, force_nrdy;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  int          cur;

  logic        sel0, sel1, sel2, rdy0, rdy1, rdy2, resp0, resp1, resp2;
  logic [31:0] rd0, rd1, rd2;
  logic        obs_rdy, obs_resp;
  logic [31:0] obs_data;

  int          passed, total, dcycles;
  int          ws_tab [3] = '{0, 3, 5};
  logic [31:0] model [3][1024];
  xfer_t       xq [$];
  obs_t        got_q [$];
  obs_t        exp_q [$];

  always #5 clk = ~clk;

  assign sel0 = hsel & (cur == 0);
  assign sel1 = hsel & (cur == 1);
  assign sel2 = hsel & (cur == 2);

  ahb_lite_mem_responder #(.AWIDTH(10), .WAIT_STATES(0), .ERR_MASK(EWIN), .ERR_MATCH(EWIN)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HWRITE(hwrite), .HTRANS(htrans),
    .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADYIN(rdy0 & ~force_nrdy),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0));

  ahb_lite_mem_responder #(.AWIDTH(10), .WAIT_STATES(3), .ERR_MASK(EWIN), .ERR_MATCH(EWIN)) dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel1), .HADDR(haddr), .HWRITE(hwrite), .HTRANS(htrans),
    .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADYIN(rdy1),
    .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rd1));

  ahb_lite_mem_responder #(.AWIDTH(10), .WAIT_STATES(5), .ERR_MASK(EWIN), .ERR_MATCH(EWIN)) dut2 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel2), .HADDR(haddr), .HWRITE(hwrite), .HTRANS(htrans),
    .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADYIN(rdy2),
    .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rd2));

  always_comb begin
    obs_rdy  = rdy0;
    obs_resp = resp0;
    obs_data = rd0;
    if (cur == 1) begin
      obs_rdy = rdy1; obs_resp = resp1; obs_data = rd1;
    end else if (cur == 2) begin
      obs_rdy = rdy2; obs_resp = resp2; obs_data = rd2;
    end
  end

  function automatic obs_t mk_obs(logic r, logic s, logic [31:0] d);
    obs_t o;
    o.rdy = r; o.resp = s; o.data = d;
    return o;
  endfunction

  function automatic xfer_t mk(bit w, logic [31:0] a, logic [2:0] s, logic [31:0] wd,
                               logic [1:0] t = 2'b10, bit sl = 1'b1, logic [2:0] b = 3'b000);
    xfer_t x;
    x.sel = sl; x.write = w; x.addr = a; x.size = s; x.wdata = wd; x.trans = t; x.burst = b;
    return x;
  endfunction

  // Any ERROR-worthy access: illegal size, misalignment, or inside the window.
  function automatic bit is_err(logic [31:0] a, logic [2:0] s);
    return ((a & EWIN) == EWIN) || (s > 3'd2) || (s == 3'd1 && a[0]) ||
           (s == 3'd2 && a[1:0] != 2'b00);
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] wd);
    int base = int'(a[1:0]);
    for (int n = base; n < base + (1 << s); n++) model[d][a[11:2]][8*n +: 8] = wd[8*n +: 8];
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0; hburst = 3'd0;
  endtask

  // Plays xq on instance d as a pipelined master; records observed and expected
  // data-phase outputs per cycle. Expectations come from the model and the rules.
  task automatic run_seq(input int d);
    xfer_t dp;
    obs_t  e, o;
    obs_t  pend [$];
    bit    dp_valid = 1'b0, adv;
    int    idx = 0, budget = 2000;
    got_q.delete(); exp_q.delete(); dcycles = 0;
    cur = d;
    while ((idx < xq.size() || dp_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
      adv = 1'b1;
      if (dp_valid) begin
        o = mk_obs(obs_rdy, obs_resp, obs_data);
        e = (pend.size() > 0) ? pend.pop_front() : mk_obs(1'b1, 1'b0, 32'h0);
        got_q.push_back(o);
        exp_q.push_back(e);
        if (dp.sel && dp.trans[1]) dcycles++;
        adv = e.rdy;
      end
      hwdata = dp_valid ? dp.wdata : 32'h0;
      if (idx < xq.size()) begin
        hsel = xq[idx].sel; haddr = xq[idx].addr; hwrite = xq[idx].write;
        htrans = xq[idx].trans; hsize = xq[idx].size; hburst = xq[idx].burst;
      end else begin
        drive_idle();
      end
      if (adv) begin
        if (dp_valid && dp.sel && dp.trans[1] && dp.write && !is_err(dp.addr, dp.size))
          model_write(d, dp.addr, dp.size, dp.wdata);
        dp_valid = 1'b0;
        if (idx < xq.size()) begin
          dp = xq[idx];
          idx++;
          dp_valid = 1'b1;
          pend.delete();
          if (!(dp.sel && dp.trans[1])) begin
            pend.push_back(mk_obs(1'b1, 1'b0, 32'h0));
          end else if (is_err(dp.addr, dp.size)) begin
            pend.push_back(mk_obs(1'b0, 1'b1, 32'h0));
            pend.push_back(mk_obs(1'b1, 1'b1, 32'h0));
          end else begin
            for (int k = 0; k < ws_tab[d]; k++) pend.push_back(mk_obs(1'b0, 1'b0, 32'h0));
            pend.push_back(mk_obs(1'b1, 1'b0, dp.write ? 32'h0 : model[d][dp.addr[11:2]]));
          end
        end
      end
    end
    if (idx < xq.size() || dp_valid) begin
      got_q.push_back('x);
      exp_q.push_back('0);
    end
  endtask

  task automatic test_reset();
    obs_t o [3];
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    o[0] = mk_obs(rdy0, resp0, rd0);
    o[1] = mk_obs(rdy1, resp1, rd1);
    o[2] = mk_obs(rdy2, resp2, rd2);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (o[i] !== mk_obs(1'b1, 1'b0, 32'h0))
        $display("FAIL reset dut%0d got rdy=%b resp=%b data=%h exp 1/0/0", i, o[i].rdy, o[i].resp, o[i].data);
      else passed++;
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read_b2b();
    xq.delete();
    xq.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF));
    xq.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
    run_seq(0);
    foreach (exp_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL b2b cyc%0d got %b/%b/%h exp %b/%b/%h", i, got_q[i].rdy, got_q[i].resp,
                 got_q[i].data, exp_q[i].rdy, exp_q[i].resp, exp_q[i].data);
      else passed++;
    end
    total++;
    if (got_q.size() != 2 || got_q[1].data !== 32'hDEAD_BEEF)
      $display("FAIL b2b_data got %0d cycles data=%h exp 2 cycles DEADBEEF", got_q.size(), got_q[1].data);
    else passed++;
  endtask

  task automatic test_byte_lanes();
    xq.delete();
    xq.push_back(mk(1'b1, 32'h20, 3'd2, 32'h1122_3344));
    xq.push_back(mk(1'b1, 32'h21, 3'd0, 32'h0000_AA00));
    xq.push_back(mk(1'b1, 32'h22, 3'd1, 32'hBBCC_0000));
    xq.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0));
    run_seq(0);
    foreach (exp_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL lanes cyc%0d got %b/%b/%h exp %b/%b/%h", i, got_q[i].rdy, got_q[i].resp,
                 got_q[i].data, exp_q[i].rdy, exp_q[i].resp, exp_q[i].data);
      else passed++;
    end
    total++;
    if (got_q[$].data !== 32'hBBCC_AA44)
      $display("FAIL lanes_word got %h exp BBCCAA44", got_q[$].data);
    else passed++;
  endtask

  task automatic test_idle_busy();
    xq.delete();
    xq.push_back(mk(1'b1, 32'h60, 3'd2, 32'h6060_6060));
    xq.push_back(mk(1'b0, 32'h60, 3'd2, 32'h0, 2'b00));
    xq.push_back(mk(1'b1, 32'h60, 3'd2, 32'hFFFF_FFFF, 2'b01));
    xq.push_back(mk(1'b0, 32'h60, 3'd2, 32'h0));
    xq.push_back(mk(1'b1, 32'h60, 3'd2, 32'h9999_9999, 2'b10, 1'b0));
    xq.push_back(mk(1'b0, 32'h60, 3'd2, 32'h0));
    run_seq(0);
    foreach (exp_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL idle_busy cyc%0d got %b/%b/%h exp %b/%b/%h", i, got_q[i].rdy, got_q[i].resp,
                 got_q[i].data, exp_q[i].rdy, exp_q[i].resp, exp_q[i].data);
      else passed++;
    end
    total++;
    if (got_q[$].data !== 32'h6060_6060)
      $display("FAIL idle_busy_word got %h exp 60606060", got_q[$].data);
    else passed++;
  endtask

  task automatic test_wait_states();
    xq.delete();
    for (int w = 0; w < 4; w++) xq.push_back(mk(1'b1, 32'(32'h100 + 4 * w), 3'd2, $urandom));
    xq.push_back(mk(1'b0, 32'h100, 3'd2, 32'h0));
    run_seq(1);
    foreach (exp_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL wait cyc%0d got %b/%b/%h exp %b/%b/%h", i, got_q[i].rdy, got_q[i].resp,
                 got_q[i].data, exp_q[i].rdy, exp_q[i].resp, exp_q[i].data);
      else passed++;
    end
    xq.delete();
    xq.push_back(mk(1'b0, 32'h100, 3'd2, 32'h0, 2'b10, 1'b1, 3'b011));
    for (int w = 1; w < 4; w++) xq.push_back(mk(1'b0, 32'(32'h100 + 4 * w), 3'd2, 32'h0, 2'b11, 1'b1, 3'b011));
    run_seq(1);
    foreach (exp_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL incr4 cyc%0d got %b/%b/%h exp %b/%b/%h", i, got_q[i].rdy, got_q[i].resp,
                 got_q[i].data, exp_q[i].rdy, exp_q[i].resp, exp_q[i].data);
      else passed++;
    end
    total++;
    if (dcycles != 16) $display("FAIL incr4_cycles got %0d exp 16", dcycles);
    else passed++;
  endtask

  task automatic test_error_window();
    xq.delete();
    xq.push_back(mk(1'b1, 32'h04, 3'd2, 32'hCAFE_F00D));
    xq.push_back(mk(1'b1, 32'hF000_0004, 3'd2, 32'h0BAD_BEEF));
    xq.push_back(mk(1'b0, 32'h04, 3'd2, 32'h0));
    run_seq(0);
    foreach (exp_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL errwin cyc%0d got %b/%b/%h exp %b/%b/%h", i, got_q[i].rdy, got_q[i].resp,
                 got_q[i].data, exp_q[i].rdy, exp_q[i].resp, exp_q[i].data);
      else passed++;
    end
    total++;
    if (got_q[1] !== mk_obs(1'b0, 1'b1, 32'h0) || got_q[2] !== mk_obs(1'b1, 1'b1, 32'h0))
      $display("FAIL errwin_resp got %b%b then %b%b exp 01 then 11", got_q[1].rdy, got_q[1].resp,
               got_q[2].rdy, got_q[2].resp);
    else passed++;
    total++;
    if (got_q[$].data !== 32'hCAFE_F00D) $display("FAIL errwin_word got %h exp CAFEF00D", got_q[$].data);
    else passed++;
  endtask

  task automatic test_illegal();
    xq.delete();
    xq.push_back(mk(1'b1, 32'h08, 3'd2, 32'h1357_2468));
    xq.push_back(mk(1'b1, 32'h0B, 3'd2, 32'hFFFF_FFFF));
    xq.push_back(mk(1'b0, 32'h08, 3'd3, 32'h0));
    xq.push_back(mk(1'b1, 32'h09, 3'd1, 32'hEEEE_EEEE));
    xq.push_back(mk(1'b0, 32'h08, 3'd2, 32'h0));
    run_seq(0);
    foreach (exp_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL illegal cyc%0d got %b/%b/%h exp %b/%b/%h", i, got_q[i].rdy, got_q[i].resp,
                 got_q[i].data, exp_q[i].rdy, exp_q[i].resp, exp_q[i].data);
      else passed++;
    end
    total++;
    if (got_q[$].data !== 32'h1357_2468) $display("FAIL illegal_word got %h exp 13572468", got_q[$].data);
    else passed++;
  endtask

  task automatic test_hreadyin_low();
    xq.delete();
    xq.push_back(mk(1'b1, 32'h50, 3'd2, 32'h0F0F_0F0F));
    run_seq(0);
    @(negedge clk);
    cur = 0; force_nrdy = 1'b1;
    hsel = 1'b1; haddr = 32'h50; hwrite = 1'b1; htrans = 2'b10; hsize = 3'd2; hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    force_nrdy = 1'b0;
    drive_idle();
    total++;
    if (rdy0 !== 1'b1 || resp0 !== 1'b0) $display("FAIL nrdy_out got %b/%b exp 1/0", rdy0, resp0);
    else passed++;
    @(negedge clk);
    xq.delete();
    xq.push_back(mk(1'b0, 32'h50, 3'd2, 32'h0));
    run_seq(0);
    total++;
    if (got_q[$].data !== 32'h0F0F_0F0F) $display("FAIL nrdy_word got %h exp 0F0F0F0F", got_q[$].data);
    else passed++;
  endtask

  task automatic test_reset_mid();
    xq.delete();
    xq.push_back(mk(1'b1, 32'h40, 3'd2, 32'h55AA_55AA));
    run_seq(2);
    @(negedge clk);
    cur = 2;
    hsel = 1'b1; haddr = 32'h40; hwrite = 1'b1; htrans = 2'b10; hsize = 3'd2;
    @(negedge clk);
    drive_idle();
    hwdata = 32'h1234_5678;
    total++;
    if (rdy2 !== 1'b0) $display("FAIL rstmid_wait got rdy=%b exp 0", rdy2);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (mk_obs(rdy2, resp2, rd2) !== mk_obs(1'b1, 1'b0, 32'h0))
      $display("FAIL rstmid_out got %b/%b/%h exp 1/0/0", rdy2, resp2, rd2);
    else passed++;
    repeat (8) @(negedge clk);
    xq.delete();
    xq.push_back(mk(1'b0, 32'h40, 3'd2, 32'h0));
    run_seq(2);
    foreach (exp_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL rstmid_rd cyc%0d got %b/%b/%h exp %b/%b/%h", i, got_q[i].rdy, got_q[i].resp,
                 got_q[i].data, exp_q[i].rdy, exp_q[i].resp, exp_q[i].data);
      else passed++;
    end
    total++;
    if (got_q[$].data !== 32'h55AA_55AA) $display("FAIL rstmid_word got %h exp 55AA55AA", got_q[$].data);
    else passed++;
  endtask

  task automatic test_random(input int d);
    xfer_t x;
    xq.delete();
    for (int w = 0; w < 16; w++) xq.push_back(mk(1'b1, 32'(4 * w), 3'd2, $urandom));
    for (int n = 0; n < 60; n++) begin
      x.sel   = ($urandom_range(0, 9) != 0);
      x.trans = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      x.write = 1'($urandom_range(0, 1));
      x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      x.addr  = {26'h0, 6'($urandom_range(0, 63))};
      if ($urandom_range(0, 9) == 0) x.addr[31:28] = 4'hF;
      x.wdata = $urandom;
      x.burst = 3'b000;
      xq.push_back(x);
    end
    run_seq(d);
    foreach (exp_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL random%0d cyc%0d got %b/%b/%h exp %b/%b/%h", d, i, got_q[i].rdy, got_q[i].resp,
                 got_q[i].data, exp_q[i].rdy, exp_q[i].resp, exp_q[i].data);
      else passed++;
    end
  endtask

  initial begin
    passed = 0; total = 0; cur = 0;
    rst = 1'b1; force_nrdy = 1'b0; hwdata = 32'h0;
    drive_idle();
    test_reset();
    test_write_read_b2b();
    test_byte_lanes();
    test_idle_busy();
    test_wait_states();
    test_error_window();
    test_illegal();
    test_hreadyin_low();
    test_reset_mid();
    test_random(0);
    test_random(1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
